memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  RISC-V MEM stage, directly downstream of execute. Takes ALU_result (address or result),
//  store data, funct3 and control from execute. Runs a valid/ready request plus response
//  handshake to data memory, with byte-lane alignment and load extension. Asserts stall
//  back to execute while an access is outstanding. Emits a one-cycle writeback packet.
// PARAMETERS
//  DATA_WIDTH    32  datapath width; only 32 supported (4 byte lanes)
//  ADDRESS_BITS  20  data-memory byte-address width
// PORTS
//  clock           in   1             single clock, rising edge
//  reset           in   1             asynchronous, active-low
//  ex_valid        in   1             execute presents an instruction this cycle
//  ex_mem_read     in   1             load
//  ex_mem_write    in   1             store (never both with ex_mem_read)
//  ex_funct3       in   3             access size/sign
//  ex_ALU_result   in   DATA_WIDTH    effective address, or result for non-mem ops
//  ex_store_data   in   DATA_WIDTH    rs2 value
//  ex_rd           in   5             destination register
//  ex_regWrite     in   1             instruction writes rd
//  stall           out  1             execute must hold its outputs
//  dmem_req_valid  out  1             request valid
//  dmem_req_ready  in   1             memory accepts request
//  dmem_req_write  out  1             1 = store
//  dmem_req_addr   out  ADDRESS_BITS  word-aligned byte address, [1:0]=0
//  dmem_req_wdata  out  DATA_WIDTH    lane-replicated store data
//  dmem_req_be     out  DATA_WIDTH/8  byte enables
//  dmem_rsp_valid  in   1             load data valid
//  dmem_rsp_rdata  in   DATA_WIDTH    load word
//  wb_valid        out  1             one-cycle pulse per completed instruction
//  wb_regWrite     out  1             writeback enable
//  wb_rd           out  5             writeback register
//  wb_data         out  DATA_WIDTH    writeback value
//  mem_fault       out  1             one-cycle pulse: misaligned or illegal funct3
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; every output 0; captured request dropped at once.
//  - FSM IDLE -> REQ -> (store: IDLE | load: WAIT) -> IDLE.
//  - IDLE, ex_valid, non-mem op: next edge wb_valid=1, wb_data=ex_ALU_result,
//    wb_rd/wb_regWrite copied; stall=0.
//  - IDLE, ex_valid, mem op, legal and aligned: stall=1 combinationally; capture
//    addr/data/be/rd/funct3; next state REQ.
//  - Legal funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU (loads only).
//  - Fault: halfword with addr[0]=1, word with addr[1:0]!=0, or any other funct3. No request
//    issued; next edge mem_fault=1 and wb_valid=0; stall=0.
//  - REQ: dmem_req_valid=1. addr/wdata/be/write held stable until dmem_req_ready. stall=1
//    except on a store handshake cycle, where stall=0, the store retires (wb_valid=0 next
//    cycle) and state goes to IDLE. A load handshake goes to WAIT.
//  - WAIT: stall=1 until dmem_rsp_valid. On that cycle stall=0; next edge wb_valid=1,
//    wb_data = extended load value; state IDLE.
//  - Execute inputs are sampled only in IDLE. Held inputs in REQ/WAIT are ignored.
//  - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{b}}; SH be=4'b0011<<{addr[1],1'b0},
//    wdata={2{h}}; SW be=4'b1111.
//  - Load: shift rdata right by 8*addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW raw.
//  - dmem_rsp_valid outside WAIT is a protocol error: ignored (assertion). Earliest response
//    is the cycle after the request handshake.
//  - Minimum latency: non-mem 1 cycle; store 2 cycles; load 3 cycles (ready=1, rsp next cycle).
//  - Reset mid-transaction: state IDLE, req_valid falls asynchronously, a late response
//    is ignored.
// STRUCTURE
//  - Package riscv_mem_pkg: funct3 localparams (F3_LB..F3_LHU), mem_state_t enum {IDLE,REQ,WAIT}.
//  - Sub-module load_align (combinational): rdata, addr[1:0], funct3 -> extended value.
//  - Store lane logic and the FSM stay in this module.
// TESTING
//  - ADD, ALU_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234, stall never 1.
//  - SB addr=0x00003, data=0xAB, ready=1 -> be=4'b1000, wdata=0xABABABAB; stall high 1 cycle.
//  - LH addr=0x2, rdata=0x8001_0000, rsp 3 cycles after handshake -> wb_data=0xFFFF8001.
//  - LHU same stimulus -> wb_data=0x00008001. LBU addr=1, rdata=0x0000_F000 -> 0x000000F0.
//  - LW addr=0x6 -> mem_fault=1 for 1 cycle, no dmem_req_valid, wb_valid=0.
//  - Load in WAIT, reset=0 -> outputs 0 at once. Response after release ignored; state IDLE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Brief    : Shared funct3 encodings, MEM-stage FSM states and access checks
//            for the RISC-V memory access stage.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  // Load/store size and sign encodings carried in funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Stores only have signed-size encodings; unsigned forms exist for loads only
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
    logic r_ok;
    r_ok = 1'b0;
    case (f3)
      F3_LB, F3_LH, F3_LW: r_ok = 1'b1;
      F3_LBU, F3_LHU:      r_ok = !is_store;
      default:             r_ok = 1'b0;
    endcase
    return r_ok;
  endfunction

  // Natural alignment check on the low address bits, keyed by access size
  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r_ok;
    r_ok = 1'b0;
    case (f3[1:0])
      2'b00:   r_ok = 1'b1;
      2'b01:   r_ok = !lo[0];
      2'b10:   r_ok = (lo == 2'b00);
      default: r_ok = 1'b0;
    endcase
    return r_ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Combinational load-data alignment: selects the addressed lane of
//            the returned word and sign/zero-extends it per funct3.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            byte_offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] load_value
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Bring the addressed byte lane down to bit 0, then extend by access type
  always_comb begin
    w_shifted  = rdata >> {byte_offset, 3'b000};
    load_value = w_shifted;
    case (funct3)
      F3_LB:   load_value = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_LH:   load_value = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  load_value = {{(DATA_WIDTH-8){1'b0}},           w_shifted[7:0]};
      F3_LHU:  load_value = {{(DATA_WIDTH-16){1'b0}},          w_shifted[15:0]};
      F3_LW:   load_value = w_shifted;
      default: load_value = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_stage
// Brief    : RISC-V MEM stage. Issues valid/ready data-memory requests with
//            byte-lane steering, waits for load responses, extends load data
//            and emits a one-cycle writeback packet. Stalls execute while an
//            access is in flight; flags misaligned/illegal accesses.
// Revision : 1.0 - initial release
// ============================================================================
module memory_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [2:0]                ex_funct3,
  input  logic [DATA_WIDTH-1:0]     ex_ALU_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic [4:0]                ex_rd,
  input  logic                      ex_regWrite,
  output logic                      stall,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_req_write,
  output logic [ADDRESS_BITS-1:0]   dmem_req_addr,
  output logic [DATA_WIDTH-1:0]     dmem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]   dmem_req_be,
  input  logic                      dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     dmem_rsp_rdata,
  output logic                      wb_valid,
  output logic                      wb_regWrite,
  output logic [4:0]                wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      mem_fault
);

  localparam int                   c_BE_W    = DATA_WIDTH / 8;
  localparam logic [c_BE_W-1:0]    c_BE_BYTE = {{(c_BE_W-1){1'b0}}, 1'b1};
  localparam logic [c_BE_W-1:0]    c_BE_HALF = {{(c_BE_W-2){1'b0}}, 2'b11};

  mem_state_t              r_state;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_BE_W-1:0]       r_be;
  logic                    r_write;
  logic [1:0]              r_lane;
  logic [2:0]              r_funct3;
  logic [4:0]              r_rd;
  logic                    r_reg_write;

  logic                    w_mem_op;
  logic                    w_access_ok;
  logic [1:0]              w_lane;
  logic [c_BE_W-1:0]       w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_load_value;

  assign w_mem_op    = ex_mem_read | ex_mem_write;
  assign w_lane      = ex_ALU_result[1:0];
  assign w_access_ok = funct3_legal(ex_funct3, ex_mem_write) &&
                       addr_aligned(ex_funct3, w_lane);

  // Byte-lane steering: enables follow the access size, data is replicated
  // across lanes so memory can pick it up from whichever lane is enabled
  always_comb begin
    w_be    = '0;
    w_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = c_BE_BYTE << w_lane;
        w_wdata = {c_BE_W{ex_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = c_BE_HALF << {w_lane[1], 1'b0};
        w_wdata = {(DATA_WIDTH/16){ex_store_data[15:0]}};
      end
      2'b10: begin
        w_be    = '1;
        w_wdata = ex_store_data;
      end
      default: begin
        w_be    = '0;
        w_wdata = ex_store_data;
      end
    endcase
  end

  load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .rdata       (dmem_rsp_rdata),
    .byte_offset (r_lane),
    .funct3      (r_funct3),
    .load_value  (w_load_value)
  );

  // Stall execute while an access is pending; released on the cycle the
  // access completes so execute can advance in lock-step with the edge
  always_comb begin
    stall = 1'b0;
    case (r_state)
      IDLE:    stall = ex_valid && w_mem_op && w_access_ok;
      REQ:     stall = !(r_write && dmem_req_ready);
      WAIT:    stall = !dmem_rsp_valid;
      default: stall = 1'b0;
    endcase
    if (!reset) begin
      stall = 1'b0;
    end
  end

  assign dmem_req_valid = (r_state == REQ);
  assign dmem_req_write = r_write;
  assign dmem_req_addr  = r_addr;
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_be    = r_be;

  // Request/response FSM plus the registered writeback and fault pulses.
  // Responses arriving outside WAIT are stray and simply not looked at.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_write     <= 1'b0;
      r_lane      <= 2'b00;
      r_funct3    <= 3'b000;
      r_rd        <= 5'd0;
      r_reg_write <= 1'b0;
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
      mem_fault   <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      mem_fault   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            if (!w_mem_op) begin
              wb_valid    <= 1'b1;
              wb_regWrite <= ex_regWrite;
              wb_rd       <= ex_rd;
              wb_data     <= ex_ALU_result;
            end else if (w_access_ok) begin
              r_addr      <= {ex_ALU_result[ADDRESS_BITS-1:2], 2'b00};
              r_wdata     <= w_wdata;
              r_be        <= w_be;
              r_write     <= ex_mem_write;
              r_lane      <= w_lane;
              r_funct3    <= ex_funct3;
              r_rd        <= ex_rd;
              r_reg_write <= ex_regWrite;
              r_state     <= REQ;
            end else begin
              mem_fault   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            r_state <= r_write ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            wb_valid    <= 1'b1;
            wb_regWrite <= r_reg_write;
            wb_rd       <= r_rd;
            wb_data     <= w_load_value;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access_stage
// Brief    : Directed self-checking bench for memory_access_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_ALU_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regWrite;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_write;
  logic [19:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        wb_valid;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  int n_checks;
  int n_fail;

  memory_access_stage #(
    .DATA_WIDTH   (32),
    .ADDRESS_BITS (20)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_ALU_result  (ex_ALU_result),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_regWrite    (ex_regWrite),
    .stall          (stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_write (dmem_req_write),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_be    (dmem_req_be),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .wb_valid       (wb_valid),
    .wb_regWrite    (wb_regWrite),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .mem_fault      (mem_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_funct3     = 3'b000;
    ex_ALU_result = 32'h0;
    ex_store_data = 32'h0;
    ex_rd         = 5'd0;
    ex_regWrite   = 1'b0;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic rw);
    ex_valid      = 1'b1;
    ex_mem_read   = rd_op;
    ex_mem_write  = wr_op;
    ex_funct3     = f3;
    ex_ALU_result = alu;
    ex_store_data = sdata;
    ex_rd         = rd;
    ex_regWrite   = rw;
  endtask

  // Store with immediate ready: stall one cycle, handshake, no writeback
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [19:0] exp_addr);
    @(negedge clock);
    issue(1'b0, 1'b1, f3, addr, sdata, 5'd0, 1'b0);
    dmem_req_ready = 1'b1;
    #1;
    check_value({tag, "_stall_idle"}, 32'(stall), 32'd1);
    check_value({tag, "_noreq_idle"}, 32'(dmem_req_valid), 32'd0);
    @(negedge clock);
    check_value({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    check_value({tag, "_req_write"}, 32'(dmem_req_write), 32'd1);
    check_value({tag, "_be"}, 32'(dmem_req_be), 32'(exp_be));
    check_value({tag, "_wdata"}, dmem_req_wdata, exp_wdata);
    check_value({tag, "_addr"}, 32'(dmem_req_addr), 32'(exp_addr));
    check_value({tag, "_stall_hs"}, 32'(stall), 32'd0);
    clear_ex();
    @(negedge clock);
    check_value({tag, "_req_done"}, 32'(dmem_req_valid), 32'd0);
    check_value({tag, "_no_wb"}, 32'(wb_valid), 32'd0);
  endtask

  // Load with immediate ready and response 'delay' cycles after the handshake
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay,
                         input logic [4:0] rd, input logic [31:0] expected);
    @(negedge clock);
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1);
    dmem_req_ready = 1'b1;
    #1;
    check_value({tag, "_stall_idle"}, 32'(stall), 32'd1);
    @(negedge clock);
    check_value({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    check_value({tag, "_req_write"}, 32'(dmem_req_write), 32'd0);
    check_value({tag, "_addr"}, 32'(dmem_req_addr), {addr[31:2], 2'b00} & 32'h000F_FFFF);
    check_value({tag, "_stall_hs"}, 32'(stall), 32'd1);
    clear_ex();
    for (int i = 1; i < delay; i++) begin
      @(negedge clock);
      check_value({tag, "_stall_wait"}, 32'(stall), 32'd1);
    end
    @(negedge clock);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = rdata;
    #1;
    check_value({tag, "_stall_rsp"}, 32'(stall), 32'd0);
    @(negedge clock);
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;
    check_value({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
    check_value({tag, "_wb_data"}, wb_data, expected);
    check_value({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
    check_value({tag, "_wb_regw"}, 32'(wb_regWrite), 32'd1);
  endtask

  // Faulting access: no request, no stall, one-cycle fault pulse
  task automatic do_fault(input string tag, input logic rd_op, input logic [2:0] f3,
                          input logic [31:0] addr);
    @(negedge clock);
    issue(rd_op, !rd_op, f3, addr, 32'h1234_5678, 5'd9, rd_op);
    dmem_req_ready = 1'b1;
    #1;
    check_value({tag, "_stall"}, 32'(stall), 32'd0);
    @(negedge clock);
    check_value({tag, "_fault"}, 32'(mem_fault), 32'd1);
    check_value({tag, "_no_wb"}, 32'(wb_valid), 32'd0);
    check_value({tag, "_no_req"}, 32'(dmem_req_valid), 32'd0);
    clear_ex();
    @(negedge clock);
    check_value({tag, "_fault_pulse"}, 32'(mem_fault), 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = 32'h0;
    clear_ex();

    // Reset state
    repeat (2) @(negedge clock);
    check_value("rst_stall", 32'(stall), 32'd0);
    check_value("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check_value("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_value("rst_wb_data", wb_data, 32'd0);
    check_value("rst_fault", 32'(mem_fault), 32'd0);
    check_value("rst_be", 32'(dmem_req_be), 32'd0);
    reset = 1'b1;

    // Non-memory op: one-cycle writeback, no stall
    @(negedge clock);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    #1;
    check_value("add_stall", 32'(stall), 32'd0);
    @(negedge clock);
    check_value("add_wb_valid", 32'(wb_valid), 32'd1);
    check_value("add_wb_data", wb_data, 32'h0000_1234);
    check_value("add_wb_rd", 32'(wb_rd), 32'd5);
    check_value("add_wb_regw", 32'(wb_regWrite), 32'd1);
    check_value("add_stall2", 32'(stall), 32'd0);
    clear_ex();
    @(negedge clock);
    check_value("add_wb_pulse", 32'(wb_valid), 32'd0);

    // Stores
    do_store("sb3", 3'b000, 32'h0000_0003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 20'h00000);
    do_store("sb1", 3'b000, 32'h0000_0101, 32'hFFFF_FF5C, 4'b0010, 32'h5C5C_5C5C, 20'h00100);
    do_store("sh0", 3'b001, 32'h0000_0040, 32'h1111_CAFE, 4'b0011, 32'hCAFE_CAFE, 20'h00040);
    do_store("sw",  3'b010, 32'h000F_FFFC, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 20'hFFFFC);

    // Store with backpressure: request held while execute inputs change
    @(negedge clock);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_000A, 32'h1234_BEEF, 5'd0, 1'b0);
    dmem_req_ready = 1'b0;
    @(negedge clock);
    check_value("shbp_req_valid", 32'(dmem_req_valid), 32'd1);
    check_value("shbp_be", 32'(dmem_req_be), 32'h0000_000C);
    check_value("shbp_wdata", dmem_req_wdata, 32'hBEEF_BEEF);
    check_value("shbp_stall", 32'(stall), 32'd1);
    ex_ALU_result = 32'h0000_0FF1;
    ex_store_data = 32'h0;
    @(negedge clock);
    check_value("shbp_hold_addr", 32'(dmem_req_addr), 32'h0000_0008);
    check_value("shbp_hold_be", 32'(dmem_req_be), 32'h0000_000C);
    check_value("shbp_hold_wdata", dmem_req_wdata, 32'hBEEF_BEEF);
    dmem_req_ready = 1'b1;
    clear_ex();
    #1;
    check_value("shbp_stall_hs", 32'(stall), 32'd0);
    @(negedge clock);
    check_value("shbp_done", 32'(dmem_req_valid), 32'd0);

    // Loads
    do_load("lh",  3'b001, 32'h0000_0002, 32'h8001_0000, 3, 5'd7,  32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0002, 32'h8001_0000, 3, 5'd8,  32'h0000_8001);
    do_load("lbu", 3'b100, 32'h0000_0001, 32'h0000_F000, 1, 5'd10, 32'h0000_00F0);
    do_load("lb",  3'b000, 32'h0000_0001, 32'h0000_F000, 1, 5'd11, 32'hFFFF_FFF0);
    do_load("lb3", 3'b000, 32'h0000_0023, 32'h7F00_0000, 2, 5'd12, 32'h0000_007F);
    do_load("lw",  3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 1, 5'd13, 32'hDEAD_BEEF);

    // Faults
    do_fault("lw_mis",  1'b1, 3'b010, 32'h0000_0006);
    do_fault("lh_mis",  1'b1, 3'b001, 32'h0000_0001);
    do_fault("sbu_ill", 1'b0, 3'b100, 32'h0000_0000);
    do_fault("f3_ill",  1'b1, 3'b011, 32'h0000_0000);

    // Reset while waiting for a load response
    @(negedge clock);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0, 5'd3, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clock);
    clear_ex();
    @(negedge clock);
    check_value("rstw_stall_before", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check_value("rstw_stall", 32'(stall), 32'd0);
    check_value("rstw_req_valid", 32'(dmem_req_valid), 32'd0);
    check_value("rstw_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0000_0055;
    #1;
    check_value("late_rsp_stall", 32'(stall), 32'd0);
    @(negedge clock);
    dmem_rsp_valid = 1'b0;
    check_value("late_rsp_wb", 32'(wb_valid), 32'd0);

    // Reset while a request is pending: request drops without a clock edge
    @(negedge clock);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0102_0304, 5'd0, 1'b0);
    dmem_req_ready = 1'b0;
    @(negedge clock);
    check_value("rstr_req_before", 32'(dmem_req_valid), 32'd1);
    clear_ex();
    reset = 1'b0;
    #1;
    check_value("rstr_req_valid", 32'(dmem_req_valid), 32'd0);
    check_value("rstr_addr", 32'(dmem_req_addr), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    dmem_req_ready = 1'b1;
    @(negedge clock);
    check_value("rstr_idle", 32'(dmem_req_valid), 32'd0);

    // Back in IDLE: normal op still retires
    issue(1'b0, 1'b0, 3'b000, 32'hA5A5_0001, 32'h0, 5'd31, 1'b1);
    @(negedge clock);
    check_value("post_wb_valid", 32'(wb_valid), 32'd1);
    check_value("post_wb_data", wb_data, 32'hA5A5_0001);
    clear_ex();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
